selector_jugador_ctrl: RTL and testbench
========================================

# selector_jugador_ctrl

Push-button front end that produces the 2-bit sprite selection code consumed by the sprite selection mux. Two raw board buttons step the selection forward or backward through the three legal codes (00 = none, 01 = Jugador1, 10 = Jugador2). Each button is synchronized and debounced. A change is staged as pending and committed only on a fixed vertical-blanking line of the VGA scan, so the displayed sprite never switches mid-frame.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- `V_COMMIT_LINE`, default 480: value of `cuentaY` on which a pending selection is committed.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `boton_sig`  in  1  raw "next" button, active-low, asynchronous to `clk`.
- `boton_ant`  in  1  raw "previous" button, active-low, asynchronous to `clk`.
- `cuentaY`  in  10  current VGA line counter, synchronous to `clk`.
- `contador_seleccionador`  out  2  committed selection code; only 00, 01, 10 are ever driven.
- `cambio`  out  1  one-cycle pulse when `contador_seleccionador` takes a new value.
- `pendiente`  out  1  high while a staged selection awaits commit.

## Operation
- **Synchronizer.** Each button is inverted to active-high, then passed through a 2-flop synchronizer.
- **Debouncer.** One per button, with a 4-state FSM:
  - States are SUELTO, CONF_PRES, PRESIONADO and CONF_SUELTA.
  - SUELTO→CONF_PRES when the synced level is 1.
  - CONF_PRES→PRESIONADO after `DEBOUNCE_CYCLES` consecutive cycles at 1.
  - CONF_PRES→SUELTO on any 0.
  - PRESIONADO→CONF_SUELTA on 0.
  - CONF_SUELTA→SUELTO after `DEBOUNCE_CYCLES` consecutive 0s.
  - CONF_SUELTA→PRESIONADO on any 1.
  - The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and clears on every state change.
- **Press events.**
  - A press event (`ev_sig` / `ev_ant`) is one cycle, asserted on the CONF_PRES→PRESIONADO transition.
  - Holding a button gives exactly one event; there is no auto-repeat.
- **Staged register `sel_next`.**
  - `ev_sig` advances 00→01→10→00.
  - `ev_ant` steps back 00→10→01→00.
  - `ev_sig` and `ev_ant` in the same cycle cancel: no change, and `pendiente` is unaffected.
  - Any accepted event sets `pendiente`.
  - Multiple events before a commit accumulate; only the final value is committed.
- **Commit.**
  - When `pendiente`=1 and `cuentaY`==`V_COMMIT_LINE`, the next edge loads `contador_seleccionador` ← `sel_next` and clears `pendiente`.
  - `cambio` pulses only if the new value differs from the old one. Example: sig then ant before a commit gives `pendiente`=1, but `cambio` stays 0.
  - `cuentaY` holds `V_COMMIT_LINE` for a full line; only the first qualifying cycle commits, because `pendiente` clears.
- **Event and commit in the same cycle.** The commit uses the post-event value of `sel_next`, and `pendiente` ends at 0.
- **Reset.**
  - `contador_seleccionador`=00, `sel_next`=00, `pendiente`=0, `cambio`=0.
  - Both FSMs go to SUELTO with counters at 0; synchronizer flops go to 0 (released).
  - A button held through reset release produces an event after the normal debounce time.
  - Reset asserted mid-debounce or with a commit pending discards all staged state.
- 11 is unreachable. If `sel_next` is ever 11, both ev_sig and ev_ant map it to 00.

## Timing
- All outputs are registered.
- Raw press to `ev_sig`: the button is first seen as 1 in synchronizer stage 2 at cycle N. `ev_sig` is high in cycle N+`DEBOUNCE_CYCLES`, and `sel_next`/`pendiente` update on the following edge.
- Commit: the qualifying cycle is C. `contador_seleccionador` and `cambio` are valid in cycle C+1; `cambio` is low again in C+2.
- Worst-case press-to-display: 2 + `DEBOUNCE_CYCLES` + one frame + 1 cycle.

## Test plan
1. **Reset and single press.** Reset, `DEBOUNCE_CYCLES`=4, `cuentaY`=0. Press `boton_sig` clean. Expect `pendiente`=1 at 2+4+1 cycles and `contador_seleccionador`=00 until `cuentaY`=480. Then expect `contador_seleccionador`=01 and a single `cambio` pulse; `pendiente`=0.
2. **Bounce rejection.** Toggle `boton_sig` every 2 cycles for 20 cycles, then release. Expect no event and `pendiente`=0. Then hold for 10 cycles: exactly one event.
3. **Wrap and reverse.** From 00, press `ant` once and commit: expect 10. Press `sig` twice and commit: expect 01. Each commit gives one `cambio`.
4. **Cancel.** From 01, press `sig` then `ant` before line 480. Expect `pendiente`=1, a commit keeping 01, and `cambio`=0. Both buttons pressed in the same cycle: no `pendiente`.
5. **Line hold.** `cuentaY` held at 480 for 800 cycles while `sig` is pressed twice. Expect one commit per event, and the same-cycle event+commit case commits the new value.
6. **Reset mid-operation.** Assert `rst` with `pendiente`=1 and a debounce in progress. Expect all outputs at reset values on the next cycle, and no stale commit at the next line 480.

Source files
------------

// File: rtl/selector_jugador_ctrl.sv
// rtl/selector_jugador_ctrl.sv - debounced two-button sprite selector with vblank-aligned commit

// Debouncer FSM for one synchronized, active-high button level.
// evento is a one-cycle strobe on the CONF_PRES to PRESIONADO transition only.
module selector_jugador_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic evento
);
  typedef enum logic [1:0] {SUELTO, CONF_PRES, PRESIONADO, CONF_SUELTA} estado_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The cycle that enters a confirm state is not counted, so the last
  // stable cycle sees the counter at DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  estado_t         estado, estado_d;
  logic [CW-1:0]   cnt, cnt_d;

  // State and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= SUELTO;
      cnt    <= '0;
    end else begin
      estado <= estado_d;
      cnt    <= cnt_d;
    end
  end

  // Next state; counter defaults to zero so it clears on every state change
  always_comb begin
    estado_d = estado;
    cnt_d    = '0;
    evento   = 1'b0;
    case (estado)
      SUELTO: begin
        if (level) estado_d = CONF_PRES;
      end
      CONF_PRES: begin
        if (!level) begin
          estado_d = SUELTO;
        end else if (cnt == CNT_LAST) begin
          estado_d = PRESIONADO;
          evento   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESIONADO: begin
        if (!level) estado_d = CONF_SUELTA;
      end
      CONF_SUELTA: begin
        if (level) begin
          estado_d = PRESIONADO;
        end else if (cnt == CNT_LAST) begin
          estado_d = SUELTO;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: estado_d = SUELTO;
    endcase
  end
endmodule

// Top: synchronizers, two debouncers, staged selection and line-aligned commit.
module selector_jugador_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int V_COMMIT_LINE   = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_sig,
  input  logic       boton_ant,
  input  logic [9:0] cuentaY,
  output logic [1:0] contador_seleccionador,
  output logic       cambio,
  output logic       pendiente
);
  logic [1:0] sync_sig, sync_ant;
  logic       ev_sig, ev_ant;
  logic [1:0] sel_next, sel_d;
  logic       commit;

  function automatic logic [1:0] paso_sig(input logic [1:0] v);
    case (v)
      2'b00:   paso_sig = 2'b01;
      2'b01:   paso_sig = 2'b10;
      default: paso_sig = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] paso_ant(input logic [1:0] v);
    case (v)
      2'b00:   paso_ant = 2'b10;
      2'b10:   paso_ant = 2'b01;
      default: paso_ant = 2'b00;
    endcase
  endfunction

  // Two-flop synchronizers on the inverted (active-high) raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sig <= '0;
      sync_ant <= '0;
    end else begin
      sync_sig <= {sync_sig[0], ~boton_sig};
      sync_ant <= {sync_ant[0], ~boton_ant};
    end
  end

  selector_jugador_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sig (
    .clk    (clk),
    .rst    (rst),
    .level  (sync_sig[1]),
    .evento (ev_sig)
  );

  selector_jugador_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ant (
    .clk    (clk),
    .rst    (rst),
    .level  (sync_ant[1]),
    .evento (ev_ant)
  );

  // Post-event staged value; simultaneous events cancel each other
  always_comb begin
    sel_d = sel_next;
    if (ev_sig && !ev_ant)      sel_d = paso_sig(sel_next);
    else if (ev_ant && !ev_sig) sel_d = paso_ant(sel_next);
    commit = pendiente && (cuentaY == 10'(V_COMMIT_LINE));
  end

  // Staged selection, pending flag and committed output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_next               <= 2'b00;
      pendiente              <= 1'b0;
      contador_seleccionador <= 2'b00;
      cambio                 <= 1'b0;
    end else begin
      sel_next <= sel_d;
      cambio   <= 1'b0;
      if (commit) begin
        // Commit wins over a same-cycle event: the event's value is taken, pending cleared
        contador_seleccionador <= sel_d;
        cambio                 <= (sel_d != contador_seleccionador);
        pendiente              <= 1'b0;
      end else if (ev_sig != ev_ant) begin
        pendiente <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_selector_jugador_ctrl.sv
// tb/tb_selector_jugador_ctrl.sv - scoreboard bench for selector_jugador_ctrl
module tb_selector_jugador_ctrl;
  localparam int DB   = 4;
  localparam int LINE = 480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       boton_sig = 1'b1;
  logic       boton_ant = 1'b1;
  logic [9:0] cuentaY = '0;
  logic [1:0] contador_seleccionador;
  logic       cambio, pendiente;

  selector_jugador_ctrl #(.DEBOUNCE_CYCLES(DB), .V_COMMIT_LINE(LINE)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .boton_sig              (boton_sig),
    .boton_ant              (boton_ant),
    .cuentaY                (cuentaY),
    .contador_seleccionador (contador_seleccionador),
    .cambio                 (cambio),
    .pendiente              (pendiente)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];
  int         m_sel = 0;
  int         m_com = 0;
  bit         m_pend = 0;
  bit         line_held = 0;
  logic [1:0] prev = 2'b00;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: codes 0,1,2 form a ring; sig is +1, ant is -1 modulo 3
  task automatic model_step(input int dir);
    m_sel  = (m_sel + 3 + dir) % 3;
    m_pend = 1;
  endtask

  task automatic model_commit();
    if (m_pend) begin
      if (m_sel != m_com) exp_q.push_back(2'(m_sel));
      m_com  = m_sel;
      m_pend = 0;
    end
  endtask

  task automatic press(input bit is_sig);
    model_step(is_sig ? 1 : -1);
    if (line_held) model_commit();
    if (is_sig) boton_sig = 1'b0; else boton_ant = 1'b0;
    tick(8);
    boton_sig = 1'b1;
    boton_ant = 1'b1;
    tick(10);
  endtask

  task automatic commit_line();
    cuentaY = 10'(LINE);
    model_commit();
    tick(3);
    cuentaY = '0;
    tick(2);
  endtask

  task automatic chk_state(input string name);
    chk({name, " sel"}, contador_seleccionador, 32'(m_com));
    chk({name, " pend"}, pendiente, 32'(m_pend));
  endtask

  // Monitor: every cambio pulse must match the next expected committed code
  always @(negedge clk) begin
    if (rst) begin
      prev = contador_seleccionador;
    end else begin
      if (cambio) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cambio: got sel %0d expected no change", contador_seleccionador);
        end else begin
          chk("commit_value", contador_seleccionador, exp_q.pop_front());
        end
      end else if (contador_seleccionador !== prev) begin
        checks++;
        errors++;
        $display("FAIL silent_change: got %0d expected %0d", contador_seleccionador, prev);
      end
      prev = contador_seleccionador;
    end
  end

  initial begin
    tick(3);
    chk("reset sel", contador_seleccionador, 0);
    chk("reset pend", pendiente, 0);
    chk("reset cambio", cambio, 0);
    rst = 1'b0;
    tick(2);

    // Single press: pendiente appears exactly 2+DB+1 edges after the raw press
    model_step(1);
    boton_sig = 1'b0;
    tick(6);
    chk("pend before debounce", pendiente, 0);
    tick(1);
    chk("pend after debounce", pendiente, 1);
    chk("no early commit", contador_seleccionador, 0);
    tick(1);
    boton_sig = 1'b1;
    tick(10);
    commit_line();
    chk_state("first commit");
    chk("first commit is 01", contador_seleccionador, 1);

    // Bounce rejection, then a clean long hold gives one event
    for (int i = 0; i < 10; i++) begin
      boton_sig = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    boton_sig = 1'b1;
    tick(10);
    chk_state("bounce");
    model_step(1);
    boton_sig = 1'b0;
    tick(10);
    boton_sig = 1'b1;
    tick(10);
    chk_state("long hold");
    commit_line();
    chk_state("long hold commit");

    // Reverse and wrap
    press(0);
    commit_line();
    chk_state("ant commit");
    press(1);
    press(1);
    commit_line();
    chk_state("sig sig commit");

    // Cancel: sig then ant leaves pending but no visible change
    press(1);
    press(0);
    chk_state("cancel pending");
    commit_line();
    chk_state("cancel commit");
    boton_sig = 1'b0;
    boton_ant = 1'b0;
    tick(8);
    boton_sig = 1'b1;
    boton_ant = 1'b1;
    tick(10);
    chk_state("both same cycle");

    // Line held at the commit value: every event commits on its own
    cuentaY = 10'(LINE);
    line_held = 1;
    press(1);
    chk_state("held press 1");
    press(1);
    chk_state("held press 2");
    line_held = 0;
    cuentaY = '0;
    tick(2);

    // Event lands in the first commit-line cycle while already pending
    press(1);
    model_step(1);
    boton_sig = 1'b0;
    tick(6);
    cuentaY = 10'(LINE);
    model_commit();
    tick(1);
    chk_state("event+commit");
    tick(1);
    chk_state("event+commit hold");
    boton_sig = 1'b1;
    cuentaY = '0;
    tick(10);

    // Randomized press sequences with commits
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) press(1'($urandom_range(0, 1)));
      chk_state("random staged");
      commit_line();
      chk_state("random commit");
    end

    // Reset with a pending selection and a debounce in flight
    press(1);
    boton_ant = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst sel", contador_seleccionador, 0);
    chk("midrst pend", pendiente, 0);
    chk("midrst cambio", cambio, 0);
    rst = 1'b0;
    boton_ant = 1'b1;
    m_sel = 0;
    m_com = 0;
    m_pend = 0;
    exp_q.delete();
    tick(10);
    commit_line();
    chk_state("no stale commit");

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
